alu_flag_reg: RTL and testbench
===============================

ALU_FLAG_REG -- requirements
Module: alu_flag_reg

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width of the result path.
REQ-002 SHALL have port: clk  input  1  single clock, all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  upstream ALU output qualifier.
REQ-005 SHALL have port: in_ready  output  1  block can accept an entry this cycle.
REQ-006 SHALL have ports: in_opcode  input  3; in_result  input  WIDTH; in_z, in_c, in_n, in_v  input  1 each. These are the ALU opcode, result and flags.
REQ-007 SHALL have port: out_valid  output  1  downstream entry available.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts.
REQ-009 SHALL have ports: out_result  output  WIDTH; out_opcode  output  3. These are the head entry.
REQ-010 SHALL have port: psr  output  4  architectural flags {N,Z,C,V}.
REQ-011 SHALL have port: flag_clr  input  1  synchronous clear of psr.
REQ-012 SHALL have port: cond  input  4  condition code to evaluate.
REQ-013 SHALL have port: cond_true  output  1  combinational result of cond against psr.

Function
REQ-014 SHALL accept on in_valid && in_ready and deliver on out_valid && out_ready.
REQ-015 SHALL buffer entries as a 2-entry skid FIFO with states EMPTY, ONE, TWO; accept-only: EMPTY->ONE, ONE->TWO; deliver-only: TWO->ONE, ONE->EMPTY; simultaneous accept+deliver holds state.
REQ-016 SHALL drive in_ready = (state != TWO) from a register, with no combinational path from out_ready.
REQ-017 SHALL present an accepted entry at out_* one cycle after acceptance when the FIFO was EMPTY, so minimum latency is 1 cycle.
REQ-018 SHALL keep out_result/out_opcode stable while out_valid && !out_ready, and SHALL preserve entry order.
REQ-019 SHALL update psr on acceptance only, per opcode mask: 000/001 update N,Z,C,V; 010-110 update N,Z and keep C,V; 111 updates none.
REQ-020 SHALL clear all psr bits on flag_clr; when flag_clr coincides with an acceptance, cleared bits are first zeroed, then the masked update bits take the accepted values.
REQ-021 SHALL evaluate cond_true as: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
REQ-022 SHALL have psr changes visible on cond_true in the cycle after the accepting edge.
REQ-023 SHALL ignore in_* data when in_valid is low, and SHALL ignore out_ready when out_valid is low.

Reset
REQ-024 SHALL on rst assertion immediately force state EMPTY, out_valid 0, in_ready 0, psr 0000, out_result 0, out_opcode 000.
REQ-025 SHALL drive in_ready 1 on the first rising edge after rst deassertion.
REQ-026 SHALL discard any buffered entries when rst asserts mid-operation, with no partial delivery.

Configuration
REQ-027 SHALL, when STICKY_OV_EN is defined, add output sticky_v (1 bit) that sets on any accepted arithmetic opcode with in_v=1 and clears only on flag_clr or rst.
REQ-028 SHALL, when STICKY_OV_EN is undefined, omit sticky_v and leave all other behaviour identical.

Verification
REQ-029 SHALL cover: reset, then accept opcode 000, result 0x00, z=1 c=1 n=0 v=0 -> out_valid next cycle, out_result 0x00, psr 0110, cond=0 -> cond_true 1.
REQ-030 SHALL cover: psr 0110, accept opcode 010, result 0x80, z=0 n=1 -> psr 1010 (C kept), cond=4 -> 1.
REQ-031 SHALL cover: out_ready held 0 for 3 valid inputs 0x11, 0x22, 0x33 -> in_ready falls after 2 accepts, 0x33 waits; release gives order 0x11, 0x22, 0x33.
REQ-032 SHALL cover: flag_clr plus accept of opcode 011 with n=1 in the same cycle -> psr 1000.
REQ-033 SHALL cover: rst asserted while state TWO -> out_valid 0 and psr 0000 before the next edge, and no stale entry after release.
REQ-034 SHALL cover, with STICKY_OV_EN: accept 001 with v=1, then 000 with v=0 -> psr V 0, sticky_v 1 until flag_clr.

Source files
------------

// File: rtl/alu_flag_reg.sv
// ALU result buffer (2-entry skid FIFO) with architectural flag register and condition evaluator.
// Define STICKY_OV_EN to add the sticky_v output (sticky overflow from arithmetic opcodes).
module alu_flag_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_opcode,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_z,
   input  logic             in_c,
   input  logic             in_n,
   input  logic             in_v,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [2:0]       out_opcode,
   output logic [3:0]       psr,
   input  logic             flag_clr,
   input  logic [3:0]       cond,
   output logic             cond_true
`ifdef STICKY_OV_EN
  ,output logic             sticky_v
`endif
);

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] head_res_q, head_res_d, skid_res_q, skid_res_d;
   logic [2:0]       head_op_q, head_op_d, skid_op_q, skid_op_d;
   logic             in_ready_q, in_ready_d;
   logic [3:0]       psr_q, psr_d;
   logic             accept, deliver;
   logic             flag_n, flag_z, flag_c, flag_v;

   assign out_valid  = (state_q != StEmpty);
   assign in_ready   = in_ready_q;
   assign out_result = head_res_q;
   assign out_opcode = head_op_q;
   assign psr        = psr_q;
   assign accept     = in_valid && in_ready_q;
   assign deliver    = out_valid && out_ready;

   always_comb begin
      state_d    = state_q;
      head_res_d = head_res_q;
      head_op_d  = head_op_q;
      skid_res_d = skid_res_q;
      skid_op_d  = skid_op_q;
      unique case (state_q)
         StEmpty: begin
            if (accept) begin
               state_d    = StOne;
               head_res_d = in_result;
               head_op_d  = in_opcode;
            end
         end
         StOne: begin
            if (accept && deliver) begin
               head_res_d = in_result;
               head_op_d  = in_opcode;
            end else if (accept) begin
               state_d    = StTwo;
               skid_res_d = in_result;
               skid_op_d  = in_opcode;
            end else if (deliver) begin
               state_d = StEmpty;
            end
         end
         StTwo: begin
            // in_ready is low here, so only a delivery can happen
            if (deliver) begin
               state_d    = StOne;
               head_res_d = skid_res_q;
               head_op_d  = skid_op_q;
            end
         end
         default: state_d = StEmpty;
      endcase
      in_ready_d = (state_d != StTwo);
   end

   // Clear first, then the opcode-masked update overrides the cleared bits.
   always_comb begin
      psr_d = flag_clr ? 4'b0000 : psr_q;
      if (accept) begin
         case (in_opcode)
            3'b000, 3'b001: psr_d = {in_n, in_z, in_c, in_v};
            3'b111:         psr_d = psr_d;
            default:        psr_d[3:2] = {in_n, in_z};
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StEmpty;
         head_res_q <= '0;
         head_op_q  <= 3'b000;
         skid_res_q <= '0;
         skid_op_q  <= 3'b000;
         in_ready_q <= 1'b0;
         psr_q      <= 4'b0000;
      end else begin
         state_q    <= state_d;
         head_res_q <= head_res_d;
         head_op_q  <= head_op_d;
         skid_res_q <= skid_res_d;
         skid_op_q  <= skid_op_d;
         in_ready_q <= in_ready_d;
         psr_q      <= psr_d;
      end
   end

`ifdef STICKY_OV_EN
   logic sticky_q, sticky_d;

   always_comb begin
      sticky_d = flag_clr ? 1'b0 : sticky_q;
      if (accept && (in_opcode[2:1] == 2'b00) && in_v) sticky_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sticky_q <= 1'b0;
      else     sticky_q <= sticky_d;
   end

   assign sticky_v = sticky_q;
`endif

   assign {flag_n, flag_z, flag_c, flag_v} = psr_q;

   always_comb begin
      cond_true = 1'b0;
      case (cond)
         4'h0: cond_true = flag_z;
         4'h1: cond_true = !flag_z;
         4'h2: cond_true = flag_c;
         4'h3: cond_true = !flag_c;
         4'h4: cond_true = flag_n;
         4'h5: cond_true = !flag_n;
         4'h6: cond_true = flag_v;
         4'h7: cond_true = !flag_v;
         4'h8: cond_true = flag_c && !flag_z;
         4'h9: cond_true = !flag_c || flag_z;
         4'hA: cond_true = (flag_n == flag_v);
         4'hB: cond_true = (flag_n != flag_v);
         4'hC: cond_true = !flag_z && (flag_n == flag_v);
         4'hD: cond_true = flag_z || (flag_n != flag_v);
         4'hE: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_alu_flag_reg.sv
// Self-checking bench for alu_flag_reg: directed scenarios plus random traffic against a
// queue-based reference model. Covers sticky_v when STICKY_OV_EN is defined.
module tb_alu_flag_reg;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready;
   logic [2:0]   in_opcode;
   logic [W-1:0] in_result;
   logic         in_z, in_c, in_n, in_v;
   logic         out_valid, out_ready;
   logic [W-1:0] out_result;
   logic [2:0]   out_opcode;
   logic [3:0]   psr;
   logic         flag_clr;
   logic [3:0]   cond;
   logic         cond_true;
`ifdef STICKY_OV_EN
   logic         sticky_v;
`endif

   alu_flag_reg #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opcode  (in_opcode),
      .in_result  (in_result),
      .in_z       (in_z),
      .in_c       (in_c),
      .in_n       (in_n),
      .in_v       (in_v),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_opcode (out_opcode),
      .psr        (psr),
      .flag_clr   (flag_clr),
      .cond       (cond),
      .cond_true  (cond_true)
`ifdef STICKY_OV_EN
     ,.sticky_v   (sticky_v)
`endif
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nmis = 0;

   // Reference model: FIFO contents as a queue of {opcode, result}, flags as plain bits.
   logic [W+2:0] mq[$];
   logic [W-1:0] got[$];
   bit           mn, mz, mc, mv, msv;
   bit           exp_rdy;

   function automatic bit cond_eval(input logic [3:0] c, input bit n, z, cf, v);
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cf;
         4'h3: return !cf;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cf && !z;
         4'h9: return !cf || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      {mn, mz, mc, mv, msv} = '0;
      exp_rdy = 1'b0;
   endtask

   // One clock: drive inputs, check pre-edge outputs, clock, then advance the model.
   task automatic cycle(input bit iv, input logic [2:0] op, input logic [W-1:0] res,
                        input bit z, input bit c, input bit n, input bit v,
                        input bit ordy, input bit clr, input logic [3:0] cnd);
      bit acc, dlv;
      in_valid = iv; in_opcode = op; in_result = res;
      in_z = z; in_c = c; in_n = n; in_v = v;
      out_ready = ordy; flag_clr = clr; cond = cnd;
      #1;
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         check("out_result", out_result, mq[0][W-1:0]);
         check("out_opcode", out_opcode, mq[0][W+2:W]);
      end
      check("psr", psr, {mn, mz, mc, mv});
      check("cond_true", cond_true, cond_eval(cnd, mn, mz, mc, mv));
`ifdef STICKY_OV_EN
      check("sticky_v", sticky_v, msv);
`endif
      acc = iv && exp_rdy;
      dlv = (mq.size() != 0) && ordy;
      if (dlv) got.push_back(out_result);
      @(posedge clk);
      #1;
      if (dlv) void'(mq.pop_front());
      if (acc) mq.push_back({op, res});
      if (clr) {mn, mz, mc, mv, msv} = '0;
      if (acc) begin
         if (op <= 3'd1) begin
            {mn, mz, mc, mv} = {n, z, c, v};
            if (v) msv = 1'b1;
         end else if (op != 3'd7) begin
            {mn, mz} = {n, z};
         end
      end
      exp_rdy = (mq.size() < 2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      in_valid = 0; in_opcode = 0; in_result = 0;
      {in_z, in_c, in_n, in_v} = 4'b0;
      out_ready = 0; flag_clr = 0; cond = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_psr", psr, 4'b0000);
      check("rst_out_result", out_result, 0);
      check("rst_out_opcode", out_opcode, 0);
      rst = 1'b0;
      cycle(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 4'hE);
      check("rdy_after_rst", in_ready, 1);

      // Arithmetic accept sets all four flags; visible one cycle later.
      cycle(1, 3'b000, 8'h00, 1, 1, 0, 0, 0, 0, 4'h0);
      check("r029_valid", out_valid, 1);
      check("r029_result", out_result, 8'h00);
      check("r029_psr", psr, 4'b0110);
      check("r029_cond", cond_true, 1);

      // Logic opcode updates N,Z and keeps C,V.
      cycle(1, 3'b010, 8'h80, 0, 0, 1, 0, 1, 0, 4'h4);
      check("r030_psr", psr, 4'b1010);
      check("r030_cond", cond_true, 1);
      cycle(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 4'h4);
      cycle(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 4'h4);

      // Backpressure: two entries fill the buffer, the third waits, order preserved.
      got.delete();
      cycle(1, 3'b111, 8'h11, 0, 0, 0, 0, 0, 0, 4'hE);
      cycle(1, 3'b111, 8'h22, 0, 0, 0, 0, 0, 0, 4'hE);
      check("r031_full", in_ready, 0);
      cycle(1, 3'b111, 8'h33, 0, 0, 0, 0, 0, 0, 4'hE);
      cycle(1, 3'b111, 8'h33, 0, 0, 0, 0, 1, 0, 4'hE);
      cycle(1, 3'b111, 8'h33, 0, 0, 0, 0, 1, 0, 4'hE);
      cycle(0, 3'b111, 8'h00, 0, 0, 0, 0, 1, 0, 4'hE);
      check("r031_count", got.size(), 3);
      if (got.size() == 3) begin
         check("r031_ord0", got[0], 8'h11);
         check("r031_ord1", got[1], 8'h22);
         check("r031_ord2", got[2], 8'h33);
      end

      // Clear coinciding with a logic-op accept.
      cycle(1, 3'b011, 8'h5A, 0, 1, 1, 1, 1, 1, 4'h4);
      check("r032_psr", psr, 4'b1000);
      cycle(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 4'h4);

      // Asynchronous reset while holding two entries.
      cycle(1, 3'b111, 8'hA1, 0, 0, 0, 0, 0, 0, 4'hE);
      cycle(1, 3'b111, 8'hA2, 0, 0, 0, 0, 0, 0, 4'hE);
      check("r033_full", in_ready, 0);
      #2 rst = 1'b1;
      #1;
      check("r033_out_valid", out_valid, 0);
      check("r033_psr", psr, 4'b0000);
      check("r033_in_ready", in_ready, 0);
      check("r033_out_result", out_result, 0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      cycle(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 4'hE);
      check("r033_rdy", in_ready, 1);
      check("r033_no_stale", out_valid, 0);

`ifdef STICKY_OV_EN
      cycle(1, 3'b001, 8'h7F, 0, 0, 0, 1, 1, 0, 4'h6);
      cycle(1, 3'b000, 8'h01, 0, 0, 0, 0, 1, 0, 4'h6);
      check("r034_v", psr[0], 0);
      check("r034_sticky", sticky_v, 1);
      cycle(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 4'h6);
      check("r034_hold", sticky_v, 1);
      cycle(0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 4'h6);
      check("r034_clr", sticky_v, 0);
`endif

      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0), 4'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
